fft_input_loader: RTL

Upstream feeder for `fft_top`: takes a free-running ADC sample strobe, writes one 2048-point frame into the FFT's four 512-word input RAM banks in natural order, then issues a single-cycle start pulse. It holds off the next frame until the FFT reports ready. It replaces the testbench-style direct RAM writes and sits between the ADC interface and `fft_top`'s `iDATA`/`iADDR_WR_x`/`iWE_x`/`iSTART` ports.

---
 rtl/fft_input_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/fft_input_loader.sv
// fft_input_loader: streams one 2048-sample frame from the ADC strobe into the
// four 512-word FFT input banks in natural order, then pulses oSTART and holds
// off the next frame until the FFT reports ready.
// Build option: define FFT_LOADER_OFFSET_EN to convert offset-binary samples
// to two's complement (MSB inversion) on the way in.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame in progress, idx held at 0, waits for iEN
// S_LOAD  | writing samples idx 0..2047 into banks idx[10:9]
// S_START | frame complete, launch pulse is registered this cycle
// S_WAIT  | FFT running; RDY ignored in first cycle, then exit on RDY

module fft_input_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iEN,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iVALID,
    input  logic              iFFT_RDY,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR,
    output logic [3:0]        oWE,
    output logic              oSTART,
    output logic              oBUSY,
    output logic              oDROP,
    output logic [15:0]       oDROP_CNT
);

    localparam int IDX_W = ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              wait_armed;
    logic              accept;
    logic              drop_evt;
    logic              last_sample;
    logic [DATA_W-1:0] data_in;

    assign last_sample = (idx == {IDX_W{1'b1}});

`ifdef FFT_LOADER_OFFSET_EN
    assign data_in = {~iDATA[DATA_W-1], iDATA[DATA_W-2:0]};
`else
    assign data_in = iDATA;
`endif

    // state register
    always_ff @(posedge iCLK) begin
        if (!iRESET) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // next-state decode; an abort in LOAD takes priority over the last write
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (iEN) state_nxt = S_LOAD;
            S_LOAD: begin
                if (!iEN)                       state_nxt = S_IDLE;
                else if (iVALID && last_sample) state_nxt = S_START;
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (wait_armed && iFFT_RDY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // per-cycle events: sample accepted into RAM, or sample discarded
    always_comb begin
        accept   = (state == S_LOAD) && iEN && iVALID;
        drop_evt = ((state == S_START) || (state == S_WAIT)) && iVALID;
    end

    // registered outputs, sample index and drop counter
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            oDATA      <= '0;
            oADDR_WR   <= '0;
            oWE        <= '0;
            oSTART     <= 1'b0;
            oBUSY      <= 1'b0;
            oDROP      <= 1'b0;
            oDROP_CNT  <= '0;
            idx        <= '0;
            wait_armed <= 1'b0;
        end else begin
            oWE        <= '0;
            oSTART     <= (state == S_START);
            oBUSY      <= (state != S_IDLE);
            oDROP      <= drop_evt;
            wait_armed <= (state == S_WAIT);
            if (accept) begin
                oDATA    <= data_in;
                oADDR_WR <= idx[ADDR_W-1:0];
                oWE      <= 4'b0001 << idx[IDX_W-1:ADDR_W];
                idx      <= idx + 1'b1;
            end else if (state_nxt == S_IDLE) begin
                idx <= '0;
            end
            if (drop_evt && (oDROP_CNT != 16'hFFFF))
                oDROP_CNT <= oDROP_CNT + 1'b1;
        end
    end

endmodule
